alu_operand_fetch: RTL
======================

// Module: alu_operand_fetch
// PURPOSE
//  Operand-fetch/issue stage directly upstream of the 32-bit ALU. Holds the
//  register file, reads two source operands, optionally swaps in a sign-extended
//  immediate, and tracks pending writes in a scoreboard that stalls on RAW hazards.
//  Drives A/B/C_in/Select from a registered output stage with a valid/ready handshake.
//  The writeback port carries ALU_out/Status back into the register file.
// PARAMETERS
//  DW    32  datapath width; must match the ALU (32)
//  AW    4   register address width; NREGS = 2**AW = 16
//  IMMW  16  immediate width, sign-extended to DW
// PORTS
//  clk         in   1     single clock, all state on rising edge
//  rst         in   1     synchronous, active-high reset
//  in_valid    in   1     instruction present
//  in_ready    out  1     stage accepts instruction this cycle
//  in_op       in   4     ALU select code, passed to out_select
//  in_rs1      in   AW    source 1 address -> A
//  in_rs2      in   AW    source 2 address -> B (ignored if in_use_imm)
//  in_rd       in   AW    destination address
//  in_use_imm  in   1     B = sext(in_imm)
//  in_imm      in   IMMW  immediate
//  in_use_carry in  1     C_in from carry flag (STATUS_CARRY_EN only)
//  out_valid   out  1     operands valid toward ALU
//  out_ready   in   1     ALU/downstream consumes
//  out_a       out  DW    ALU operand A
//  out_b       out  DW    ALU operand B
//  out_c_in    out  1     ALU carry-in
//  out_select  out  4     ALU Select
//  out_rd      out  AW    destination tag travelling with the op
//  wb_en       in   1     writeback strobe
//  wb_addr     in   AW    writeback register
//  wb_data     in   DW    writeback value (ALU_out)
//  wb_status   in   4     ALU Status {C,N,V,Z}
// BEHAVIOUR
//  - Reset: out_valid=0; out_a/out_b=0; out_c_in=0; out_select=0; out_rd=0;
//    scoreboard=0; carry flag=0; all registers=0. in_ready=0 during reset.
//  - R0 reads as 0, writes to R0 are dropped, R0 is never marked pending.
//  - Register write: on wb_en && wb_addr!=0, reg[wb_addr]<=wb_data; pending[wb_addr]<=0.
//  - Read bypass: if wb_en && wb_addr==rsX (rsX!=0), same-cycle wb_data is used.
//  - Hazard: hz = in_valid && ((pending[rs1] && !(wb_en&&wb_addr==rs1)) ||
//    (!in_use_imm && pending[rs2] && !(wb_en&&wb_addr==rs2))).
//  - in_ready = !rst && (!out_valid || out_ready) && !hz.
//  - Accept (in_valid && in_ready): output register loads next edge (1-cycle latency);
//    pending[in_rd]<=1 if in_rd!=0. Same-cycle wb clear of that reg loses (set wins).
//  - out_valid && !out_ready: every out_* holds stable; no new accept.
//  - out_valid && out_ready && no accept: out_valid<=0 (data holds).
//  - Back-to-back: full throughput when no hazard and out_ready=1.
//  - Immediate: out_b = {{(DW-IMMW){in_imm[IMMW-1]}}, in_imm}.
//  - Reset mid-operation: in-flight op dropped, scoreboard cleared, register contents zeroed.
//  - wb to a non-pending register is legal: it writes the register and leaves pending unchanged.
// CONFIGURATION
//  STATUS_CARRY_EN defined: carry flag <= wb_status[3] on wb_en (bypassed same cycle);
//    out_c_in = in_use_carry ? carry : 0, registered with operands.
//  undefined: no carry flag; wb_status and in_use_carry ignored; out_c_in=0 always.
// TESTING
//  1 rst=1 one edge, then idle -> out_valid=0, in_ready=1, out_a=out_b=0.
//  2 wb R3=0x0000_0005; issue op=4 rs1=3 rs2=0 rd=4 -> next cycle out_a=5,
//    out_b=0, out_select=4, out_rd=4, out_valid=1.
//  3 issue rd=5; next op reads rs1=5 -> in_ready=0 until wb R5=0x1234; same cycle
//    in_ready=1; following cycle out_a=0x1234.
//  4 use_imm imm=0xFFF0 -> out_b=0xFFFF_FFF0; out_ready=0 for 3 cycles -> outputs stable.
//  5 wb addr=0 data=0xDEAD, then read rs1=0 -> out_a=0, no stall ever on R0.
//  6 STATUS_CARRY_EN: wb_status=4'b1000, then use_carry op -> out_c_in=1;
//    without the macro -> out_c_in=0.

Source files
------------

// File: rtl/alu_operand_fetch.sv
// Operand-fetch/issue stage feeding the 32-bit ALU: register file, RAW scoreboard,
// registered valid/ready output. Optional carry flag enabled by STATUS_CARRY_EN.
module alu_operand_fetch #(
  parameter int DW   = 32,
  parameter int AW   = 4,
  parameter int IMMW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_use_imm,
  input  logic [IMMW-1:0] in_imm,
  input  logic            in_use_carry,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_a,
  output logic [DW-1:0]   out_b,
  output logic            out_c_in,
  output logic [3:0]      out_select,
  output logic [AW-1:0]   out_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  input  logic [3:0]      wb_status
);

  localparam int NREGS = 2**AW;

  logic [DW-1:0]    regs_q [NREGS];
  logic [DW-1:0]    regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;

  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_a_q, out_a_d;
  logic [DW-1:0]   out_b_q, out_b_d;
  logic            out_c_in_q, out_c_in_d;
  logic [3:0]      out_select_q, out_select_d;
  logic [AW-1:0]   out_rd_q, out_rd_d;

  logic            wb_live;
  logic            wb_hit1, wb_hit2;
  logic            rs1_hz, rs2_hz, hz;
  logic            ready_int, accept;
  logic [DW-1:0]   rs1_data, rs2_data, imm_ext, b_data;
  logic            c_in_next;

  assign wb_live = wb_en && (wb_addr != '0);
  assign wb_hit1 = wb_en && (wb_addr == in_rs1);
  assign wb_hit2 = wb_en && (wb_addr == in_rs2);

  // A same-cycle writeback to a pending source resolves the hazard via the bypass.
  assign rs1_hz    = pending_q[in_rs1] && !wb_hit1;
  assign rs2_hz    = !in_use_imm && pending_q[in_rs2] && !wb_hit2;
  assign hz        = in_valid && (rs1_hz || rs2_hz);
  assign ready_int = !rst && (!out_valid_q || out_ready) && !hz;
  assign accept    = in_valid && ready_int;
  assign in_ready  = ready_int;

  always_comb begin
    rs1_data = '0;
    if (in_rs1 != '0) begin
      if (wb_hit1) rs1_data = wb_data;
      else         rs1_data = regs_q[in_rs1];
    end
    rs2_data = '0;
    if (in_rs2 != '0) begin
      if (wb_hit2) rs2_data = wb_data;
      else         rs2_data = regs_q[in_rs2];
    end
    imm_ext = {{(DW-IMMW){in_imm[IMMW-1]}}, in_imm};
    b_data  = in_use_imm ? imm_ext : rs2_data;
  end

`ifdef STATUS_CARRY_EN
  logic carry_q, carry_d, carry_cur;
  logic unused_status;

  assign unused_status = ^wb_status[2:0];

  always_comb begin
    carry_cur = wb_en ? wb_status[3] : carry_q;
    carry_d   = carry_cur;
    c_in_next = in_use_carry && carry_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end
`else
  logic unused_carry;

  assign unused_carry = ^{wb_status, in_use_carry};
  assign c_in_next    = 1'b0;
`endif

  always_comb begin
    regs_d = regs_q;
    if (wb_live) regs_d[wb_addr] = wb_data;
  end

  // Issue-time set is applied after writeback clear so the new pending mark wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_live) pending_d[wb_addr] = 1'b0;
    if (accept && (in_rd != '0)) pending_d[in_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_c_in_d   = out_c_in_q;
    out_select_d = out_select_q;
    out_rd_d     = out_rd_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_a_d      = rs1_data;
      out_b_d      = b_data;
      out_c_in_d   = c_in_next;
      out_select_d = in_op;
      out_rd_d     = in_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_c_in_q   <= 1'b0;
      out_select_q <= '0;
      out_rd_q     <= '0;
    end else begin
      regs_q       <= regs_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_c_in_q   <= out_c_in_d;
      out_select_q <= out_select_d;
      out_rd_q     <= out_rd_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_c_in   = out_c_in_q;
  assign out_select = out_select_q;
  assign out_rd     = out_rd_q;

endmodule
